// File: rtl/branch_sequencer_if.sv
// Handshake and datapath-control bundle between the top-level instruction
// sequencer (master) and the branch-class control sequencer (slave).
interface branch_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  start;
    logic [31:0]           instruction;
    logic [3:0]            status;
    logic                  alu_zero;
    logic [30:0]           controlword;
    logic [DATA_WIDTH-1:0] K;
    logic                  busy;
    logic                  done;
    logic                  taken;
    logic                  illegal;

    modport master (
        output start, instruction, status, alu_zero,
        input  controlword, K, busy, done, taken, illegal
    );

    modport slave (
        input  start, instruction, status, alu_zero,
        output controlword, K, busy, done, taken, illegal
    );
endinterface

// File: rtl/branch_sequencer.sv
// Multi-cycle LEGv8 branch-class control sequencer (B, BL, CBZ, CBNZ, BR).
// Optional B.cond decode/evaluation is enabled by defining BRANCH_COND_EN.
module branch_sequencer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter logic [4:0]  LINK_REG   = 5'd30
) (
    input  logic              clock,
    input  logic              reset_n,
    branch_sequencer_if.slave bus
);

    localparam int unsigned OP6_W  = 6;
    localparam int unsigned OP8_W  = 8;
    localparam int unsigned OP11_W = 11;
    localparam int unsigned REG_W  = 5;

    localparam logic [OP6_W-1:0]  OP_B     = 6'b000101;
    localparam logic [OP6_W-1:0]  OP_BL    = 6'b100101;
    localparam logic [OP8_W-1:0]  OP_CBZ   = 8'b10110100;
    localparam logic [OP8_W-1:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [OP8_W-1:0]  OP_BCOND = 8'b01010100;
    localparam logic [OP11_W-1:0] OP_BR    = 11'b11010110000;

    localparam logic [1:0] PSEL_HOLD = 2'b00;
    localparam logic [1:0] PSEL_INC  = 2'b01;
    localparam logic [1:0] PSEL_REG  = 2'b10;
    localparam logic [1:0] PSEL_REL  = 2'b11;

    localparam logic [4:0] FSEL_PASS_A = 5'b00100;
    localparam logic [4:0] REG_ZR      = 5'd31;

    typedef struct packed {
        logic [1:0] psel;
        logic [4:0] da;
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] fsel;
        logic       reg_w;
        logic       ram_w;
        logic       en_mem;
        logic       en_alu;
        logic       en_b;
        logic       en_pc;
        logic       b_sel;
        logic       pc_sel;
        logic       sl;
    } ctrl_t;

    localparam ctrl_t CW_NOP = '{
        psel: PSEL_HOLD, da: REG_ZR, sa: REG_ZR, sb: REG_ZR, fsel: 5'd0,
        reg_w: 1'b0, ram_w: 1'b0, en_mem: 1'b0, en_alu: 1'b0, en_b: 1'b0,
        en_pc: 1'b0, b_sel: 1'b0, pc_sel: 1'b0, sl: 1'b0
    };

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LINK     = 3'd1,
        S_TEST     = 3'd2,
        S_BRANCH   = 3'd3,
        S_BRREG    = 3'd4,
        S_NOTTAKEN = 3'd5,
        S_ILLEGAL  = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] k_q, k_d;
    logic [REG_W-1:0]      reg_q, reg_d;
    logic                  cbnz_q, cbnz_d;

    state_t                dec_state_c;
    logic [DATA_WIDTH-1:0] dec_k_c;
    logic [REG_W-1:0]      dec_reg_c;
    logic                  dec_cbnz_c;
    logic                  accept_c;
    logic                  test_taken_c;

    ctrl_t                 cw_c;
    logic                  busy_c;
    logic                  done_c;
    logic                  taken_c;
    logic                  illegal_c;

`ifdef BRANCH_COND_EN
    // LEGv8 condition evaluation; status is {N,Z,C,V}.
    function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, base;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        unique case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        cond_true = (cond[3:1] == 3'd7) ? 1'b1 : (base ^ cond[0]);
    endfunction
`endif

    // Instruction decode: first state, offset and register field of an accepted word.
    always_comb begin : decode
        dec_state_c = S_ILLEGAL;
        dec_k_c     = '0;
        dec_reg_c   = bus.instruction[4:0];
        dec_cbnz_c  = 1'b0;
        if (bus.instruction[31:26] == OP_B) begin
            dec_state_c = S_BRANCH;
            dec_k_c     = DATA_WIDTH'($signed(bus.instruction[25:0]));
        end else if (bus.instruction[31:26] == OP_BL) begin
            dec_state_c = S_LINK;
            dec_k_c     = DATA_WIDTH'($signed(bus.instruction[25:0]));
        end else if (bus.instruction[31:24] == OP_CBZ || bus.instruction[31:24] == OP_CBNZ) begin
            dec_state_c = S_TEST;
            dec_k_c     = DATA_WIDTH'($signed(bus.instruction[23:5]));
            dec_cbnz_c  = (bus.instruction[31:24] == OP_CBNZ);
`ifdef BRANCH_COND_EN
        end else if (bus.instruction[31:24] == OP_BCOND) begin
            dec_state_c = cond_true(bus.instruction[3:0], bus.status) ? S_BRANCH : S_NOTTAKEN;
            dec_k_c     = DATA_WIDTH'($signed(bus.instruction[23:5]));
`endif
        end else if (bus.instruction[31:21] == OP_BR) begin
            dec_state_c = S_BRREG;
            dec_reg_c   = bus.instruction[9:5];
        end
    end

    // State and latched-field registers.
    always_ff @(posedge clock or negedge reset_n) begin : state_reg
        if (!reset_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            reg_q   <= '0;
            cbnz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            reg_q   <= reg_d;
            cbnz_q  <= cbnz_d;
        end
    end

    // Next state; a start in a done cycle chains straight into the next instruction.
    always_comb begin : next_state
        state_d      = state_q;
        k_d          = k_q;
        reg_d        = reg_q;
        cbnz_d       = cbnz_q;
        accept_c     = bus.start && ((state_q == S_IDLE) || done_c);
        test_taken_c = cbnz_q ? ~bus.alu_zero : bus.alu_zero;
        unique case (state_q)
            S_IDLE:     state_d = S_IDLE;
            S_LINK:     state_d = S_BRANCH;
            S_TEST:     state_d = test_taken_c ? S_BRANCH : S_NOTTAKEN;
            S_BRANCH,
            S_BRREG,
            S_NOTTAKEN,
            S_ILLEGAL:  state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (accept_c) begin
            state_d = dec_state_c;
            k_d     = dec_k_c;
            reg_d   = dec_reg_c;
            cbnz_d  = dec_cbnz_c;
        end
    end

    // Control outputs depend only on state and latched fields, never on start.
    always_comb begin : outputs
        cw_c      = CW_NOP;
        busy_c    = (state_q != S_IDLE);
        done_c    = 1'b0;
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        unique case (state_q)
            S_LINK: begin
                cw_c.psel  = PSEL_HOLD;
                cw_c.da    = LINK_REG;
                cw_c.reg_w = 1'b1;
                cw_c.en_pc = 1'b1;
            end
            S_TEST: begin
                cw_c.sa   = reg_q;
                cw_c.fsel = FSEL_PASS_A;
            end
            S_BRANCH: begin
                cw_c.psel   = PSEL_REL;
                cw_c.pc_sel = 1'b1;
                cw_c.en_alu = 1'b1;
                done_c      = 1'b1;
                taken_c     = 1'b1;
            end
            S_BRREG: begin
                cw_c.sa   = reg_q;
                cw_c.psel = PSEL_REG;
                done_c    = 1'b1;
                taken_c   = 1'b1;
            end
            S_NOTTAKEN: begin
                cw_c.psel = PSEL_INC;
                done_c    = 1'b1;
            end
            S_ILLEGAL: begin
                cw_c.psel = PSEL_INC;
                done_c    = 1'b1;
                illegal_c = 1'b1;
            end
            default: cw_c = CW_NOP;
        endcase
    end

    assign bus.controlword = cw_c;
    assign bus.K           = k_q;
    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.taken       = taken_c;
    assign bus.illegal     = illegal_c;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed testbench for branch_sequencer; B.cond expectations follow BRANCH_COND_EN.
module tb_branch_sequencer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    // Hand-computed control words: {Psel,DA,SA,SB,Fsel,regW,ramW,EN_MEM,EN_ALU,EN_B,EN_PC,Bsel,PCsel,SL}
    localparam logic [30:0] CW_NOP   = 31'h1FFFC000;
    localparam logic [30:0] CW_LINK  = 31'h1EFFC108;
    localparam logic [30:0] CW_TEST5 = 31'h1F2FC800;
    localparam logic [30:0] CW_BR    = 31'h7FFFC022;
    localparam logic [30:0] CW_NT    = 31'h3FFFC000;
    localparam logic [30:0] CW_BRR9  = 31'h5F4FC000;

    localparam logic [31:0] I_B_M1   = 32'h17FFFFFF;
    localparam logic [31:0] I_BL_10  = 32'h94000010;
    localparam logic [31:0] I_CBZ5   = 32'hB4FFFFE5;
    localparam logic [31:0] I_CBNZ5  = 32'hB5FFFFE5;
    localparam logic [31:0] I_BGT_2  = 32'h5400004C;
    localparam logic [31:0] I_BR9    = 32'hD61F0120;
    localparam logic [31:0] I_BAD    = 32'h00000000;

    localparam logic [63:0] K_M1 = 64'hFFFF_FFFF_FFFF_FFFF;

    branch_sequencer_if #(.DATA_WIDTH(64)) bus ();

    branch_sequencer #(.DATA_WIDTH(64), .LINK_REG(5'd30)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr);
        bus.start       = 1'b1;
        bus.instruction = instr;
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.instruction = '0;
        bus.status      = '0;
        bus.alu_zero    = 1'b0;

        // reset state
        #12;
        chk("rst_cw", 64'(bus.controlword), 64'(CW_NOP));
        chk("rst_k", bus.K, 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_taken", 64'(bus.taken), 64'd0);
        chk("rst_illegal", 64'(bus.illegal), 64'd0);
        rst_n = 1'b1;
        tick();

        // B with imm26 all ones: branch in cycle 1, K = -1
        issue(I_B_M1);
        tick();
        bus.start = 1'b0;
        chk("b_cw", 64'(bus.controlword), 64'(CW_BR));
        chk("b_k", bus.K, K_M1);
        chk("b_done", 64'(bus.done), 64'd1);
        chk("b_taken", 64'(bus.taken), 64'd1);
        chk("b_busy", 64'(bus.busy), 64'd1);
        tick();
        chk("b_idle_busy", 64'(bus.busy), 64'd0);
        chk("b_idle_cw", 64'(bus.controlword), 64'(CW_NOP));
        chk("b_k_hold", bus.K, K_M1);

        // BL imm26=0x10: link write then branch
        issue(I_BL_10);
        tick();
        bus.start = 1'b0;
        chk("bl_link_cw", 64'(bus.controlword), 64'(CW_LINK));
        chk("bl_link_done", 64'(bus.done), 64'd0);
        chk("bl_k", bus.K, 64'h10);
        tick();
        chk("bl_br_cw", 64'(bus.controlword), 64'(CW_BR));
        chk("bl_br_done", 64'(bus.done), 64'd1);
        chk("bl_br_taken", 64'(bus.taken), 64'd1);
        tick();

        // CBZ X5 taken; a start during TEST must be ignored
        issue(I_CBZ5);
        tick();
        bus.alu_zero = 1'b1;
        issue(I_BR9);
        chk("cbz_test_cw", 64'(bus.controlword), 64'(CW_TEST5));
        chk("cbz_test_done", 64'(bus.done), 64'd0);
        tick();
        bus.start = 1'b0;
        chk("cbz_t_cw", 64'(bus.controlword), 64'(CW_BR));
        chk("cbz_t_k", bus.K, K_M1);
        chk("cbz_t_taken", 64'(bus.taken), 64'd1);
        tick();
        chk("cbz_ign_busy", 64'(bus.busy), 64'd0);

        // CBZ X5 not taken
        issue(I_CBZ5);
        tick();
        bus.start    = 1'b0;
        bus.alu_zero = 1'b0;
        tick();
        chk("cbz_nt_cw", 64'(bus.controlword), 64'(CW_NT));
        chk("cbz_nt_done", 64'(bus.done), 64'd1);
        chk("cbz_nt_taken", 64'(bus.taken), 64'd0);
        chk("cbz_nt_illegal", 64'(bus.illegal), 64'd0);
        tick();

        // CBNZ X5 with alu_zero=0 is taken
        issue(I_CBNZ5);
        tick();
        bus.start    = 1'b0;
        bus.alu_zero = 1'b0;
        tick();
        chk("cbnz_cw", 64'(bus.controlword), 64'(CW_BR));
        chk("cbnz_taken", 64'(bus.taken), 64'd1);
        tick();

        // B.GT, flags N=1 V=1 Z=0: true
        bus.status = 4'b1001;
        issue(I_BGT_2);
        tick();
        bus.start = 1'b0;
`ifdef BRANCH_COND_EN
        chk("bgt_t_cw", 64'(bus.controlword), 64'(CW_BR));
        chk("bgt_t_k", bus.K, 64'd2);
        chk("bgt_t_taken", 64'(bus.taken), 64'd1);
`else
        chk("bgt_ill_cw", 64'(bus.controlword), 64'(CW_NT));
        chk("bgt_ill_flag", 64'(bus.illegal), 64'd1);
        chk("bgt_ill_k", bus.K, 64'd0);
`endif
        chk("bgt_t_done", 64'(bus.done), 64'd1);
        tick();

        // B.GT, flags Z=1: false
        bus.status = 4'b0100;
        issue(I_BGT_2);
        tick();
        bus.start = 1'b0;
        chk("bgt_f_cw", 64'(bus.controlword), 64'(CW_NT));
        chk("bgt_f_taken", 64'(bus.taken), 64'd0);
`ifdef BRANCH_COND_EN
        chk("bgt_f_illegal", 64'(bus.illegal), 64'd0);
`else
        chk("bgt_f_illegal", 64'(bus.illegal), 64'd1);
`endif
        tick();

        // unrecognised opcode
        issue(I_BAD);
        tick();
        bus.start = 1'b0;
        chk("ill_cw", 64'(bus.controlword), 64'(CW_NT));
        chk("ill_flag", 64'(bus.illegal), 64'd1);
        chk("ill_done", 64'(bus.done), 64'd1);
        chk("ill_k", bus.K, 64'd0);
        tick();

        // back-to-back: BR X9, then B accepted in BR's done cycle
        issue(I_BR9);
        tick();
        issue(I_B_M1);
        chk("b2b_brr_cw", 64'(bus.controlword), 64'(CW_BRR9));
        chk("b2b_brr_done", 64'(bus.done), 64'd1);
        chk("b2b_brr_k", bus.K, 64'd0);
        tick();
        bus.start = 1'b0;
        chk("b2b_b_cw", 64'(bus.controlword), 64'(CW_BR));
        chk("b2b_b_k", bus.K, K_M1);
        chk("b2b_b_done", 64'(bus.done), 64'd1);
        tick();
        chk("b2b_idle", 64'(bus.busy), 64'd0);

        // reset mid-BL in LINK: immediate return to reset values, no done
        issue(I_BL_10);
        tick();
        bus.start = 1'b0;
        chk("rl_regw", 64'(bus.controlword[8]), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rl_cw", 64'(bus.controlword), 64'(CW_NOP));
        chk("rl_busy", 64'(bus.busy), 64'd0);
        chk("rl_k", bus.K, 64'd0);
        tick();
        chk("rl_done", 64'(bus.done), 64'd0);
        chk("rl_regw_off", 64'(bus.controlword[8]), 64'd0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("rl_after_busy", 64'(bus.busy), 64'd0);
        chk("rl_after_done", 64'(bus.done), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Multi-cycle branch-class control sequencer for the LEGv8 datapath. It replaces the single-state unconditional-branch control block and covers B, BL, CBZ, CBNZ, BR and, optionally, B.cond. It owns its own state register, emits the 31-bit datapath control word and the sign-extended offset K, and handshakes with the top-level instruction sequencer via start/done. It sits beside the other instruction-class control blocks, and its outputs are muxed onto the shared control bus.

## Interface
- DATA_WIDTH, 64, width of K and of the datapath.
- LINK_REG, 30, register written by BL.
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  accept `instruction` and `status` this cycle.
- instruction  input  32  branch-class instruction word.
- status  input  4  {N,Z,C,V} flags, sampled with start.
- alu_zero  input  1  ALU zero output, sampled in TEST.
- controlword  output  31  {Psel[1:0],DA[4:0],SA[4:0],SB[4:0],Fsel[4:0],regW,ramW,EN_MEM,EN_ALU,EN_B,EN_PC,Bsel,PCsel,SL}.
- K  output  DATA_WIDTH  sign-extended word offset.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse in the final execute cycle.
- taken  output  1  valid with done; 1 = PC redirected.
- illegal  output  1  valid with done; unrecognised opcode.

## Operation
- Decode on the `instruction` input when start is accepted:
  - B: [31:26]=000101.
  - BL: [31:26]=100101.
  - CBZ: [31:24]=10110100.
  - CBNZ: [31:24]=10110101.
  - B.cond: [31:24]=01010100, cond=[3:0].
  - BR: [31:21]=11010110000, Rn=[9:5].
- Instruction, status and K are latched at accept. K is sign-extended:
  - imm26 [25:0] for B/BL.
  - imm19 [23:5] for CB*/B.cond.
  - 0 for BR and illegal opcodes.
- Psel encoding: 00 hold, 01 PC+4, 10 PC←A bus, 11 PC←PC+(K<<2).
- NOP control word: DA=SA=SB=31, all other fields 0 (0x1FFFC000).
- States: IDLE, LINK, TEST, BRANCH, BRREG, NOTTAKEN, ILLEGAL.
- Accept transitions:
  - B → BRANCH.
  - BL → LINK.
  - CBZ/CBNZ → TEST.
  - B.cond → BRANCH if cond true, else NOTTAKEN.
  - BR → BRREG.
  - Other opcodes → ILLEGAL.
- LINK: EN_PC=1, regW=1, DA=LINK_REG, Psel=00. Next state is BRANCH.
- TEST: SA=Rt[4:0], Fsel=00100 (pass A), EN_ALU=0, regW=0, SL=0. Taken when alu_zero==1 for CBZ, or alu_zero==0 for CBNZ. Next state is BRANCH if taken, else NOTTAKEN.
- BRANCH: Psel=11, PCsel=1, EN_ALU=1. done=1, taken=1.
- BRREG: SA=Rn, Psel=10. done=1, taken=1.
- NOTTAKEN: Psel=01. done=1, taken=0.
- ILLEGAL: NOP control word, Psel=01. done=1, illegal=1.
- Condition codes:
  - EQ Z, NE !Z.
  - HS C, LO !C.
  - MI N, PL !N.
  - VS V, VC !V.
  - HI C&!Z, LS !(C&!Z).
  - GE N==V, LT N!=V.
  - GT !Z&(N==V), LE !GT.
  - AL/NV always true.
- start is honoured only in IDLE or in a done cycle (back-to-back issue). It is ignored otherwise.
- controlword, busy, done, taken and illegal are combinational from the state register and latched fields only. There is no path from start.

## Timing
- Reset values: state IDLE, controlword 0x1FFFC000, K 0, busy 0, done 0, taken 0, illegal 0.
- Latency, with start in cycle 0:
  - B, BR, B.cond, illegal: done in cycle 1.
  - BL, CBZ, CBNZ: done in cycle 2.
- alu_zero is sampled at the clock edge ending TEST. The taken decision is registered there.
- Start in a done cycle: the next instruction's first state is entered in the following cycle, with no IDLE gap.
- Reset asserted mid-operation: immediate return to reset values.
  - No partial write: a BL aborted in LINK before its edge does not write.
  - done is not pulsed.
- K is held stable from accept until the next accept.

## Configuration
- BRANCH_COND_EN defined: B.cond is decoded and evaluated as above.
- BRANCH_COND_EN undefined: the B.cond encoding goes to ILLEGAL, status is unused, and the cond-evaluation logic is absent.

## Test plan
- Reset: assert reset_n=0 mid-BL in LINK → controlword 0x1FFFC000, busy=0, no regW pulse, done stays 0.
- B, imm26=0x3FFFFFF: start → cycle 1 has Psel=11, PCsel=1, K=0xFFFFFFFFFFFFFFFF, done=1, taken=1.
- BL, imm26=0x10: cycle 1 has regW=1, DA=30, EN_PC=1 → cycle 2 has Psel=11, K=0x10, done=1.
- CBZ X5, imm19=0x7FFFF:
  - alu_zero=1 in TEST → BRANCH, K=-1, taken=1.
  - Repeat with alu_zero=0 → NOTTAKEN, Psel=01, taken=0.
- B.GT with status {N,Z,C,V}=1001 → taken in cycle 1. With 0100 → NOTTAKEN. Without BRANCH_COND_EN the same encoding → illegal=1.
- Back-to-back: BR X9 then B issued in BR's done cycle → Psel=10 with SA=9, then Psel=11 on consecutive cycles. Start asserted during TEST is ignored.
